// File: rtl/pm_reset_sequencer.sv
// pm_reset_sequencer: debounced power-good qualification, reset hold-off, trip latching and warn counting.
module pm_reset_sequencer #(
  parameter int NumConverters = 8,
  parameter int DebounceCycles = 16,
  parameter int HoldoffCycles = 32,
  parameter int AutoRetry = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pgood_bus,
  input  logic        fault,
  input  logic        warn,
  input  logic        eoc,
  input  logic        clear,
  output logic        sys_reset,
  output logic        power_ok,
  output logic        fault_latched,
  output logic [1:0]  trip_src,
  output logic [31:0] fail_mask,
  output logic [7:0]  warn_count,
  output logic [2:0]  state
);
  typedef enum logic [2:0] {QUALIFY = 3'd0, HOLDOFF = 3'd1, RUN = 3'd2, TRIP = 3'd3} state_t;
  localparam logic [31:0] Mask = NumConverters >= 32 ? 32'hFFFF_FFFF : (32'd1 << NumConverters) - 32'd1;
  localparam logic [15:0] DebLast = 16'(DebounceCycles - 1);
  localparam logic [15:0] HoldLast = 16'(HoldoffCycles - 1);
  state_t st, st_n;
  logic [15:0] cnt, cnt_n;
  logic [31:0] lost;
  logic good, trip, retry;
  assign lost = ~pgood_bus & Mask;
  assign good = ~|lost & ~fault;
  assign retry = (AutoRetry != 0) && cnt == HoldLast;
  assign state = st;
  always_comb begin
    st_n = st;
    cnt_n = 16'd0;
    trip = 1'b0;
    case (st)
      QUALIFY: begin
        st_n = good && cnt == DebLast ? HOLDOFF : QUALIFY;
        cnt_n = good && cnt != DebLast ? cnt + 16'd1 : 16'd0;
      end
      HOLDOFF: begin
        st_n = !good ? QUALIFY : cnt == HoldLast ? RUN : HOLDOFF;
        cnt_n = good && cnt != HoldLast ? cnt + 16'd1 : 16'd0;
      end
      RUN: begin
        trip = !good;
        st_n = good ? RUN : TRIP;
      end
      TRIP: begin
        st_n = clear || retry ? QUALIFY : TRIP;
        cnt_n = clear || retry || AutoRetry == 0 ? 16'd0 : cnt + 16'd1;
      end
      default: st_n = TRIP;
    endcase
  end
  // a trip on the same edge as clear keeps only the freshly captured status
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st <= QUALIFY;
      cnt <= 16'd0;
      sys_reset <= 1'b1;
      power_ok <= 1'b0;
      fault_latched <= 1'b0;
      trip_src <= 2'b0;
      fail_mask <= 32'd0;
      warn_count <= 8'd0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      sys_reset <= st_n != RUN;
      power_ok <= st_n == RUN;
      fault_latched <= trip | (fault_latched & ~clear);
      fail_mask <= (clear ? 32'd0 : fail_mask) | (trip ? lost : 32'd0);
      trip_src <= (clear ? 2'b0 : trip_src) | (trip ? {fault, |lost} : 2'b0);
      warn_count <= clear ? 8'd0 : eoc && warn && warn_count != 8'hFF ? warn_count + 8'd1 : warn_count;
    end
  end
endmodule

// File: tb/tb_pm_reset_sequencer.sv
// tb_pm_reset_sequencer: scoreboard bench running AutoRetry=0 and AutoRetry=1 instances against a reference model.
module tb_pm_reset_sequencer;
  localparam int D = 16;
  localparam int H = 32;
  typedef struct packed {
    logic [2:0]  st;
    logic        sr;
    logic        po;
    logic        fl;
    logic [1:0]  ts;
    logic [31:0] fm;
    logic [7:0]  wc;
  } exp_t;
  logic clock = 0, reset = 1;
  logic [31:0] pg = 0;
  logic ft = 0, wn = 0, ec = 0, cl = 0;
  logic sr0, po0, fl0, sr1, po1, fl1;
  logic [1:0] ts0, ts1;
  logic [31:0] fm0, fm1;
  logic [7:0] wc0, wc1;
  logic [2:0] st0, st1;
  int checks = 0, errors = 0;
  exp_t q0[$], q1[$];
  int ph[2], cn[2], wc[2];
  bit fl[2];
  bit [1:0] ts[2];
  bit [31:0] fm[2];

  pm_reset_sequencer #(.NumConverters(4), .DebounceCycles(D), .HoldoffCycles(H), .AutoRetry(0)) u0 (
    .clock(clock), .reset(reset), .pgood_bus(pg), .fault(ft), .warn(wn), .eoc(ec), .clear(cl),
    .sys_reset(sr0), .power_ok(po0), .fault_latched(fl0), .trip_src(ts0), .fail_mask(fm0),
    .warn_count(wc0), .state(st0));
  pm_reset_sequencer #(.NumConverters(4), .DebounceCycles(D), .HoldoffCycles(H), .AutoRetry(1)) u1 (
    .clock(clock), .reset(reset), .pgood_bus(pg), .fault(ft), .warn(wn), .eoc(ec), .clear(cl),
    .sys_reset(sr1), .power_ok(po1), .fault_latched(fl1), .trip_src(ts1), .fail_mask(fm1),
    .warn_count(wc1), .state(st1));

  always #5 clock = ~clock;

  function automatic void cmp(string nm, logic [47:0] a, logic [47:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, a, e);
    end
  endfunction

  always @(negedge clock) begin
    if (q0.size() > 0) cmp("u0_outputs", {st0, sr0, po0, fl0, ts0, fm0, wc0}, q0.pop_front());
    if (q1.size() > 0) cmp("u1_outputs", {st1, sr1, po1, fl1, ts1, fm1, wc1}, q1.pop_front());
  end

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit [31:0] lost;
      bit good, trip;
      exp_t e;
      lost = ~pg & 32'hF;
      good = lost == 0 && !ft;
      trip = 0;
      if (reset) begin
        ph[i] = 0; cn[i] = 0; fl[i] = 0; ts[i] = 0; fm[i] = 0; wc[i] = 0;
      end else begin
        if (ph[i] == 0) begin
          if (!good) cn[i] = 0;
          else if (cn[i] + 1 == D) begin ph[i] = 1; cn[i] = 0; end
          else cn[i]++;
        end else if (ph[i] == 1) begin
          if (!good) begin ph[i] = 0; cn[i] = 0; end
          else if (cn[i] + 1 == H) begin ph[i] = 2; cn[i] = 0; end
          else cn[i]++;
        end else if (ph[i] == 2) begin
          if (!good) begin trip = 1; ph[i] = 3; cn[i] = 0; end
        end else begin
          if (cl || (i == 1 && cn[i] + 1 == H)) begin ph[i] = 0; cn[i] = 0; end
          else if (i == 1) cn[i]++;
        end
        if (cl) begin fl[i] = 0; ts[i] = 0; fm[i] = 0; wc[i] = 0; end
        else if (ec && wn && wc[i] < 255) wc[i]++;
        if (trip) begin fl[i] = 1; fm[i] |= lost; ts[i] |= {ft, lost != 0}; end
      end
      e.st = 3'(ph[i]);
      e.sr = ph[i] != 2;
      e.po = ph[i] == 2;
      e.fl = fl[i];
      e.ts = ts[i];
      e.fm = fm[i];
      e.wc = 8'(wc[i]);
      if (i == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic good_bus(input logic [3:0] low);
    pg = ($urandom() & ~32'hF) | {28'd0, low};
  endtask

  task automatic run_good(input int n);
    for (int k = 0; k < n; k++) begin
      good_bus(4'hF); ft = 0; cl = 0; ec = 0;
      tick();
    end
  endtask

  task automatic async_reset();
    @(negedge clock);
    #1 reset = 1;
    #1;
    cmp("async_state0", {45'd0, st0}, 48'd0);
    cmp("async_sysrst0", {47'd0, sr0}, 48'd1);
    cmp("async_state1", {45'd0, st1}, 48'd0);
    cmp("async_pok1", {47'd0, po1}, 48'd0);
    tick();
    reset = 0;
  endtask

  initial begin
    tick();
    tick();
    reset = 0;
    for (int k = 0; k < 65; k++) begin
      good_bus(k == 10 ? 4'hB : 4'hF);
      tick();
    end
    cmp("run_after_glitch", {45'd0, st0}, 48'd2);
    good_bus(4'hB);
    tick();
    run_good(100);
    ft = 1;
    tick();
    ft = 0;
    run_good(1000);
    cl = 1;
    tick();
    cl = 0;
    run_good(60);
    good_bus(4'hE); cl = 1;
    tick();
    cl = 0;
    run_good(40);
    for (int k = 0; k < 350; k++) begin
      good_bus(4'hF); ec = 1; wn = (k % 7) != 6;
      tick();
    end
    cl = 1;
    tick();
    cl = 0; ec = 0;
    for (int k = 0; k < 3000; k++) begin
      good_bus($urandom_range(0, 39) == 0 ? 4'($urandom()) : 4'hF);
      ft = $urandom_range(0, 299) == 0;
      cl = $urandom_range(0, 149) == 0;
      ec = $urandom_range(0, 2) == 0;
      wn = 1'($urandom());
      tick();
    end
    async_reset();
    run_good(20);
    cmp("in_holdoff", {45'd0, st1}, 48'd1);
    async_reset();
    run_good(60);
    @(negedge clock);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending want 0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pm_reset_sequencer.md
# pm_reset_sequencer

Downstream consumer of the power-monitor output stage. It qualifies the per-rail pgood bus with a consecutive-cycle debounce, then holds the system in reset for a programmable hold-off before releasing it. It trips back into reset on any rail loss or firmware fault, and latches which rails failed. It also counts firmware warn events at end-of-conversion for status readback.

## Interface
- NumConverters, 8, number of monitored rails; valid 1..32; pgood_bus bits at and above this index are ignored
- DebounceCycles, 16, consecutive all-good samples required; valid 1..65535
- HoldoffCycles, 32, cycles held in reset after qualification, and the AutoRetry wait; valid 1..65535
- AutoRetry, 0, 0 = TRIP held until clear; 1 = TRIP auto-exits after HoldoffCycles

- clock  in  1  block clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- pgood_bus  in  32  per-rail power-good, active-high, individual-rail mode
- fault  in  1  firmware fault level
- warn  in  1  firmware warn level
- eoc  in  1  end-of-conversion pulse, one clock wide
- clear  in  1  one-cycle pulse: clears latched status, exits TRIP
- sys_reset  out  1  active-high system reset
- power_ok  out  1  high only in RUN
- fault_latched  out  1  sticky trip indication
- trip_src  out  2  bit0 = rail loss caused trip, bit1 = fault caused trip
- fail_mask  out  32  sticky per-rail failure capture; bits at and above NumConverters are always 0
- warn_count  out  8  saturating count of eoc pulses with warn high
- state  out  3  encoding: QUALIFY = 0, HOLDOFF = 1, RUN = 2, TRIP = 3

## Operation
- good = (AND of pgood_bus[NumConverters-1:0]) & ~fault.
- cnt is a 16-bit internal counter.
- Reset values: state = QUALIFY, cnt = 0, sys_reset = 1, power_ok = 0, fault_latched = 0, trip_src = 0, fail_mask = 0, warn_count = 0.
- QUALIFY (sys_reset = 1):
  - if good and cnt == DebounceCycles-1: go to HOLDOFF, cnt = 0
  - else if good: cnt + 1
  - else: cnt = 0
- HOLDOFF (sys_reset = 1):
  - if !good: go to QUALIFY, cnt = 0; this does not trip
  - else if cnt == HoldoffCycles-1: go to RUN, cnt = 0
  - else: cnt + 1
- RUN (sys_reset = 0, power_ok = 1): if !good, go to TRIP, cnt = 0, and in the same edge:
  - fault_latched = 1
  - fail_mask |= ~pgood_bus masked to NumConverters bits
  - trip_src |= {fault, rail_loss}
- TRIP (sys_reset = 1):
  - clear: go to QUALIFY, cnt = 0
  - else if AutoRetry and cnt == HoldoffCycles-1: go to QUALIFY, cnt = 0
  - else: cnt + 1 (only when AutoRetry = 1)
- clear in any state zeroes fault_latched, trip_src, fail_mask and warn_count. Outside TRIP it has no effect on state.
- warn_count increments on each cycle with eoc & warn, and saturates at 255.
- Encodings 4..7 are unreachable; if entered, next state = TRIP.

## Timing
- All outputs are registered (Moore); no combinational path from inputs to outputs.
- Qualification latency: good sampled high at edges 1..D (D = DebounceCycles) gives state = HOLDOFF after edge D.
  - With H = HoldoffCycles, state = RUN and sys_reset = 0 after edge D+H.
- Trip latency: !good sampled at edge N while in RUN gives sys_reset = 1 and fault_latched = 1 after edge N. Exactly one cycle from input change to output.
- Simultaneous events:
  - clear with a trip condition in RUN: trip wins; the status registers take their capture values, not zero.
  - clear with a TRIP-state AutoRetry expiry: go to QUALIFY with the latches cleared.
  - clear with eoc & warn: warn_count = 0.
- Async reset mid-operation: all outputs take their reset values immediately, without waiting for a clock edge. First qualification begins at the first edge after reset deasserts.
- Rail glitch: a one-cycle pgood drop during QUALIFY or HOLDOFF restarts the full debounce.

## Test plan
- NumConverters = 4, D = 16, H = 32; pgood_bus = 0x0F from reset, fault = 0 -> HOLDOFF after edge 16, sys_reset falls after edge 48, power_ok = 1.
- Same parameters; pgood_bus = 0x0F with bit 2 pulsed low for 1 cycle at cycle 10 -> cnt restarts; RUN is reached at edge 10+16+32.
- In RUN, pgood_bus goes 0x0F -> 0x0B -> sys_reset = 1 next edge, state = TRIP, fail_mask = 0x04, trip_src = 2'b01. Bits 4..31 are toggled throughout with no effect.
- In RUN, fault = 1 with the bus good -> TRIP, trip_src = 2'b10, fail_mask = 0. With AutoRetry = 0, the block holds TRIP for 1000 cycles; a clear pulse then moves it to QUALIFY with all latches zero.
- AutoRetry = 1, H = 32; trip then inputs restored -> QUALIFY after 32 cycles in TRIP, RUN after 16 + 32 more.
- 300 eoc pulses with warn = 1 interleaved with 50 eoc pulses with warn = 0 -> warn_count = 255. Clear -> 0. Async reset asserted mid-HOLDOFF -> sys_reset = 1, state = 0 immediately.
